// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared state encoding, stat width and round-robin index wrap for fifo_wr_arbiter
package fifo_arb_pkg;
  typedef enum logic {IDLE, BURST} state_t;
  localparam int STAT_W = 16;
  function automatic int rr_wrap(input int idx, input int n);
    return idx >= n ? idx - n : idx;
  endfunction
endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: producer valid/ready/data/last bundle plus the FIFO write-side signals
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_we;
  logic [DATA_WIDTH-1:0]         fifo_wdata;
  logic                          fifo_full;
  logic                          fifo_pop;
  modport master (
    output req_valid, req_data, req_last, fifo_full, fifo_pop,
    input  req_ready, fifo_we, fifo_wdata
  );
  modport slave (
    input  req_valid, req_data, req_last, fifo_full, fifo_pop,
    output req_ready, fifo_we, fifo_wdata
  );
endinterface

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// rr_picker: combinational round-robin search for the first valid requester starting at rr_ptr
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      rr_ptr_i,
  output logic               any_valid_o,
  output logic [IW-1:0]      winner_o
);
  // scan farthest-first so the candidate closest to rr_ptr is the one left standing
  always_comb begin
    any_valid_o = |req_i;
    winner_o    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req_i[rr_wrap(int'(rr_ptr_i) + k, NUM_REQ)]) winner_o = IW'(rr_wrap(int'(rr_ptr_i) + k, NUM_REQ));
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-locking arbiter sharing one FIFO write port, credit based; ARB_STATS_EN adds beat counters
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_BURST  = 4,
  localparam int IW = $clog2(NUM_REQ),
  localparam int CW = $clog2(FIFO_DEPTH + 1),
  localparam int BW = $clog2(MAX_BURST + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  fifo_wr_arbiter_if.slave          bus,
  output logic [IW-1:0]             owner,
  output logic                      busy,
  output logic [CW-1:0]             credits,
  output logic                      credit_err,
  output logic [NUM_REQ*STAT_W-1:0] stat_beats
);
  state_t        state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d, owner_q, owner_d, winner;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;
  logic [CW-1:0] credits_q, credits_d;
  logic          credit_err_q, credit_err_d, any_valid, can_wr, transfer;
  rr_picker #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i      (bus.req_valid),
    .rr_ptr_i   (rr_ptr_q),
    .any_valid_o(any_valid),
    .winner_o   (winner)
  );
  assign can_wr         = state_q == BURST && credits_q != '0 && !bus.fifo_full && !rst;
  assign transfer       = can_wr && bus.req_valid[owner_q];
  assign bus.req_ready  = can_wr ? NUM_REQ'(1) << owner_q : '0;
  assign bus.fifo_we    = transfer;
  assign bus.fifo_wdata = transfer ? bus.req_data[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign owner          = owner_q;
  assign busy           = state_q == BURST;
  assign credits        = credits_q;
  assign credit_err     = credit_err_q;
  // grant on a free slot, then hold the owner until its last beat or the burst cap
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    if (state_q == IDLE && any_valid && credits_q != '0) begin
      state_d    = BURST;
      owner_d    = winner;
      beat_cnt_d = '0;
    end
    if (transfer) begin
      beat_cnt_d = beat_cnt_q + 1'b1;
      if (bus.req_last[owner_q] || beat_cnt_q == BW'(MAX_BURST - 1)) begin
        state_d  = IDLE;
        rr_ptr_d = IW'(rr_wrap(int'(owner_q) + 1, NUM_REQ));
      end
    end
  end
  // free-slot tracking; a pop with nothing outstanding is flagged instead of overflowing
  always_comb begin
    credits_d    = credits_q;
    credit_err_d = credit_err_q;
    if (transfer && !bus.fifo_pop) credits_d = credits_q - 1'b1;
    else if (bus.fifo_pop && !transfer && credits_q == CW'(FIFO_DEPTH)) credit_err_d = 1'b1;
    else if (bus.fifo_pop && !transfer) credits_d = credits_q + 1'b1;
  end
  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      beat_cnt_q   <= '0;
      credits_q    <= CW'(FIFO_DEPTH);
      credit_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      beat_cnt_q   <= beat_cnt_d;
      credits_q    <= credits_d;
      credit_err_q <= credit_err_d;
    end
  end
`ifdef ARB_STATS_EN
  logic [NUM_REQ-1:0][STAT_W-1:0] stat_q;
  // saturating per-requester count of accepted beats
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++)
      if (rst) stat_q[i] <= '0;
      else if (transfer && owner_q == IW'(i) && stat_q[i] != '1) stat_q[i] <= stat_q[i] + 1'b1;
  end
  assign stat_beats = stat_q;
`else
  assign stat_beats = '0;
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: vector table, directed corner sequences and random traffic against a reference model
module tb_fifo_wr_arbiter;
  localparam int N = 4, DW = 8, DEPTH = 8, MB = 4;
  localparam logic [N*DW-1:0] D = {8'h13, 8'h12, 8'h11, 8'h10};
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] owner;
  logic busy, credit_err;
  logic [3:0] credits;
  logic [N*16-1:0] stat_beats;
  int checks = 0, errors = 0;
  int m_owner, m_busy, m_beats, m_ptr, m_free, m_err;
  int m_cnt[N];
  int wq[$];
  logic s_we, s_bsy;
  logic [7:0] s_wd;
  logic [1:0] s_own;
  logic [3:0] s_cr;
  typedef struct {
    logic [N-1:0] v, l;
    logic p, we;
    logic [7:0] wd;
    logic [1:0] own;
    logic bsy;
    logic [3:0] cr;
  } vec_t;
  vec_t tbl[10];
  fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();
  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .bus(bus), .owner(owner), .busy(busy),
    .credits(credits), .credit_err(credit_err), .stat_beats(stat_beats)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic model_reset();
    m_owner = 0; m_busy = 0; m_beats = 0; m_ptr = 0; m_free = DEPTH; m_err = 0;
    foreach (m_cnt[i]) m_cnt[i] = 0;
  endtask
  task automatic cycle(input logic [N-1:0] v, l, input logic [N*DW-1:0] d, input logic p, f, r);
    bit ok, wr;
    int k;
    logic [N*16-1:0] se;
    @(negedge clk);
    bus.req_valid = v; bus.req_last = l; bus.req_data = d; bus.fifo_pop = p; bus.fifo_full = f; rst = r;
    #1;
    ok = !r && m_busy != 0 && m_free > 0 && !f;
    wr = ok && v[m_owner];
    se = '0;
`ifdef ARB_STATS_EN
    for (int i = 0; i < N; i++) se[i*16 +: 16] = m_cnt[i][15:0];
`endif
    chk("ready", bus.req_ready, ok ? (64'd1 << m_owner) : 64'd0);
    chk("we", bus.fifo_we, wr);
    chk("wdata", bus.fifo_wdata, wr ? d[m_owner*DW +: DW] : 8'h00);
    chk("owner", owner, m_owner);
    chk("busy", busy, m_busy);
    chk("credits", credits, m_free);
    chk("credit_err", credit_err, m_err);
    chk("stat_beats", stat_beats, se);
    s_we = bus.fifo_we; s_wd = bus.fifo_wdata; s_own = owner; s_bsy = busy; s_cr = credits;
    if (bus.fifo_we) wq.push_back(int'(bus.fifo_wdata[1:0]));
    @(posedge clk);
    if (r) model_reset();
    else begin
      if (m_busy == 0) begin
        if (v != 0 && m_free > 0) begin
          k = 0;
          while (!v[(m_ptr + k) % N]) k++;
          m_owner = (m_ptr + k) % N; m_busy = 1; m_beats = 0;
        end
      end else if (wr) begin
        m_beats++;
        if (m_cnt[m_owner] < 65535) m_cnt[m_owner]++;
        if (l[m_owner] || m_beats == MB) begin m_busy = 0; m_ptr = (m_owner + 1) % N; end
      end
      if (wr && !p) m_free--;
      else if (p && !wr) begin
        if (m_free == DEPTH) m_err = 1;
        else m_free++;
      end
    end
    #1;
  endtask
  initial begin
    tbl[0] = '{4'hF, 4'hF, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 4'd8};
    tbl[1] = '{4'hF, 4'hF, 1'b0, 1'b1, 8'h10, 2'd0, 1'b1, 4'd8};
    tbl[2] = '{4'hF, 4'hF, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 4'd7};
    tbl[3] = '{4'hF, 4'hF, 1'b0, 1'b1, 8'h11, 2'd1, 1'b1, 4'd7};
    tbl[4] = '{4'hF, 4'hF, 1'b0, 1'b0, 8'h00, 2'd1, 1'b0, 4'd6};
    tbl[5] = '{4'hF, 4'hF, 1'b0, 1'b1, 8'h12, 2'd2, 1'b1, 4'd6};
    tbl[6] = '{4'hF, 4'hF, 1'b0, 1'b0, 8'h00, 2'd2, 1'b0, 4'd5};
    tbl[7] = '{4'hF, 4'hF, 1'b0, 1'b1, 8'h13, 2'd3, 1'b1, 4'd5};
    tbl[8] = '{4'hF, 4'hF, 1'b0, 1'b0, 8'h00, 2'd3, 1'b0, 4'd4};
    tbl[9] = '{4'hF, 4'hF, 1'b0, 1'b1, 8'h10, 2'd0, 1'b1, 4'd4};
    model_reset();
    bus.req_valid = '0; bus.req_last = '0; bus.req_data = '0; bus.fifo_pop = 1'b0; bus.fifo_full = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_credits", credits, 8);
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_we", bus.fifo_we, 0);
    chk("rst_err", credit_err, 0);
    chk("rst_busy", busy, 0);
    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].v, tbl[i].l, D, tbl[i].p, 1'b0, 1'b0);
      chk($sformatf("tbl%0d_we", i), s_we, tbl[i].we);
      chk($sformatf("tbl%0d_wdata", i), s_wd, tbl[i].wd);
      chk($sformatf("tbl%0d_owner", i), s_own, tbl[i].own);
      chk($sformatf("tbl%0d_busy", i), s_bsy, tbl[i].bsy);
      chk($sformatf("tbl%0d_credits", i), s_cr, tbl[i].cr);
    end
    cycle('0, '0, D, 1'b0, 1'b0, 1'b1);
    wq.delete();
    for (int i = 0; i < 9; i++) cycle(4'b1100, 4'b1000, D, 1'b0, 1'b0, 1'b0);
    chk("burst_cap_count", wq.size(), 6);
    if (wq.size() == 6) begin
      int exp_w[6] = '{2, 2, 2, 2, 3, 2};
      for (int i = 0; i < 6; i++) chk($sformatf("burst_cap_writer%0d", i), wq[i], exp_w[i]);
    end
    cycle('0, '0, D, 1'b0, 1'b0, 1'b1);
    wq.delete();
    for (int i = 0; i < 14; i++) cycle(4'b0001, 4'b0000, D, 1'b0, 1'b0, 1'b0);
    chk("exhaust_writes", wq.size(), 8);
    chk("exhaust_credits", credits, 0);
    chk("exhaust_ready", bus.req_ready, 0);
    wq.delete();
    cycle(4'b0001, 4'b0000, D, 1'b1, 1'b0, 1'b0);
    chk("pop_credit", credits, 1);
    for (int i = 0; i < 4; i++) cycle(4'b0001, 4'b0000, D, 1'b0, 1'b0, 1'b0);
    chk("pop_one_write", wq.size(), 1);
    chk("pop_credits_zero", credits, 0);
    cycle('0, '0, D, 1'b0, 1'b0, 1'b1);
    wq.delete();
    for (int i = 0; i < 4; i++) cycle(4'b0010, 4'b0000, D, 1'b0, 1'b0, 1'b0);
    chk("pre_sim_credits", credits, 5);
    cycle(4'b0010, 4'b0000, D, 1'b1, 1'b0, 1'b0);
    chk("sim_wr_pop_we", s_we, 1);
    chk("sim_wr_pop_credits", credits, 5);
    for (int i = 0; i < 3; i++) cycle('0, '0, D, 1'b1, 1'b0, 1'b0);
    chk("refill_credits", credits, 8);
    chk("refill_err", credit_err, 0);
    cycle('0, '0, D, 1'b1, 1'b0, 1'b0);
    chk("over_pop_err", credit_err, 1);
    chk("over_pop_credits", credits, 8);
    for (int i = 0; i < 3; i++) cycle(4'b0100, 4'b0100, D, 1'b0, 1'b0, 1'b0);
    chk("err_sticky", credit_err, 1);
    cycle('0, '0, D, 1'b0, 1'b0, 1'b1);
    chk("err_cleared", credit_err, 0);
    for (int i = 0; i < 3; i++) cycle(4'b0010, 4'b0000, D, 1'b0, 1'b0, 1'b0);
    chk("mid_owner", owner, 1);
    cycle(4'b0010, 4'b0000, D, 1'b0, 1'b0, 1'b1);
    chk("mid_rst_no_we", s_we, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_credits", credits, 8);
    chk("mid_rst_owner", owner, 0);
    chk("mid_rst_stats", stat_beats, 0);
    cycle(4'b1001, 4'b1001, D, 1'b0, 1'b0, 1'b0);
    chk("post_rst_grant", owner, 0);
    chk("post_rst_busy", busy, 1);
    for (int i = 0; i < 3000; i++)
      cycle(N'($urandom), N'($urandom & $urandom), (N*DW)'($urandom), $urandom_range(0, 2) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 299) == 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
